// File: rtl/sb_pipe_cfg.sv
// Switch-block channel with per-track configurable pipelining, loaded over a serial config chain.
// Optional SB_PIPE_PARITY_EN adds a trailing even-parity bit to the chain and checks it on load.
//
// state    | meaning
// UNCONFIG | no valid configuration, routing outputs held at 0
// SHIFT    | config chain shifting while prog_en is high
// ACTIVE   | configuration accepted, tracks routed with their programmed delay
module sb_pipe_cfg #(
  parameter int CHAN_WIDTH = 64,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_en,
  input  logic                  ccff_head,
  output logic                  ccff_tail,
  output logic                  cfg_done,
  output logic                  cfg_err,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  output logic [CHAN_WIDTH-1:0] chanx_left_out
);

  localparam int CFG_W     = $clog2(PIPE_DEPTH + 1);
  localparam int CHAIN_LEN = CHAN_WIDTH * CFG_W;
`ifdef SB_PIPE_PARITY_EN
  localparam int CHAIN_TOT = CHAIN_LEN + 1;
  localparam int FLD_LSB   = 1;
`else
  localparam int CHAIN_TOT = CHAIN_LEN;
  localparam int FLD_LSB   = 0;
`endif
  localparam int CNT_W = $clog2(CHAIN_TOT + 2);

  typedef enum logic [1:0] {
    ST_UNCONFIG = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_err_set;
  logic                   w_run;
  logic                   w_load_ok;
  logic [CHAIN_TOT-1:0]   r_cfg;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_err;
  logic [CHAIN_LEN-1:0]   w_fields;
  logic [CHAN_WIDTH-1:0]  r_pipe_r [PIPE_DEPTH];
  logic [CHAN_WIDTH-1:0]  r_pipe_l [PIPE_DEPTH];

  assign w_fields = r_cfg[FLD_LSB +: CHAIN_LEN];

`ifdef SB_PIPE_PARITY_EN
  assign w_load_ok = (r_cnt == CNT_W'(CHAIN_TOT)) && !(^r_cfg);
`else
  assign w_load_ok = (r_cnt == CNT_W'(CHAIN_TOT));
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_UNCONFIG;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_run       = (r_state == ST_ACTIVE) && !prog_en && !reset;
    if (prog_en) begin
      w_state_nxt = ST_SHIFT;
    end else if (r_state == ST_SHIFT) begin
      if (w_load_ok) begin
        w_state_nxt = ST_ACTIVE;
      end else begin
        w_state_nxt = ST_UNCONFIG;
        w_err_set   = 1'b1;
      end
    end
  end

  // Counter restarts at 1 on entry because the entry cycle already shifts a bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (prog_en) begin
      r_cfg <= {r_cfg[CHAIN_TOT-2:0], ccff_head};
      r_err <= 1'b0;
      if (r_state != ST_SHIFT)              r_cnt <= CNT_W'(1);
      else if (r_cnt != CNT_W'(CHAIN_TOT + 1)) r_cnt <= r_cnt + CNT_W'(1);
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_run) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_pipe_r[k] <= '0;
        r_pipe_l[k] <= '0;
      end
    end else begin
      r_pipe_r[0] <= chanx_left_in;
      r_pipe_l[0] <= chanx_right_in;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        r_pipe_r[k] <= r_pipe_r[k-1];
        r_pipe_l[k] <= r_pipe_l[k-1];
      end
    end
  end

  for (genvar i = 0; i < CHAN_WIDTH; i++) begin : g_trk
    logic [CFG_W-1:0] w_fld;
    logic [CFG_W-1:0] w_d;
    logic             w_r;
    logic             w_l;

    assign w_fld = w_fields[i*CFG_W +: CFG_W];
    assign w_d   = (w_fld > CFG_W'(PIPE_DEPTH)) ? CFG_W'(PIPE_DEPTH) : w_fld;

    always_comb begin
      w_r = chanx_left_in[i];
      w_l = chanx_right_in[i];
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        if (w_d == CFG_W'(k)) begin
          w_r = r_pipe_r[k-1][i];
          w_l = r_pipe_l[k-1][i];
        end
      end
    end

    assign chanx_right_out[i] = w_run & w_r;
    assign chanx_left_out[i]  = w_run & w_l;
  end

  assign cfg_done  = w_run;
  assign cfg_err   = r_err & !prog_en & !reset;
  assign ccff_tail = r_cfg[CHAIN_TOT-1] & !reset;

endmodule

// File: tb/tb_sb_pipe_cfg.sv
// Scoreboard bench for sb_pipe_cfg at CHAN_WIDTH=4, PIPE_DEPTH=2 (8-bit chain, 9 with SB_PIPE_PARITY_EN).
module tb_sb_pipe_cfg;
  localparam int CW = 4;
  localparam int PD = 2;
`ifdef SB_PIPE_PARITY_EN
  localparam int CTOT = 9;
`else
  localparam int CTOT = 8;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_en;
  logic          ccff_head;
  logic          ccff_tail;
  logic          cfg_done;
  logic          cfg_err;
  logic [CW-1:0] li;
  logic [CW-1:0] ro;
  logic [CW-1:0] ri;
  logic [CW-1:0] lo;

  int errors = 0;
  int checks = 0;

  logic [CW-1:0] q_r[$];
  logic [CW-1:0] q_l[$];
  logic          q_t[$];

  sb_pipe_cfg #(.CHAN_WIDTH(CW), .PIPE_DEPTH(PD)) dut (
    .clk             (clk),
    .reset           (reset),
    .prog_en         (prog_en),
    .ccff_head       (ccff_head),
    .ccff_tail       (ccff_tail),
    .cfg_done        (cfg_done),
    .cfg_err         (cfg_err),
    .chanx_left_in   (li),
    .chanx_right_out (ro),
    .chanx_right_in  (ri),
    .chanx_left_out  (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shifts the low n bits of 'bits', MSB first, leaving prog_en low for the exit cycle.
  task automatic shift_bits(input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      prog_en   = 1'b1;
      ccff_head = bits[k];
      tick();
    end
    prog_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] w);
`ifdef SB_PIPE_PARITY_EN
    shift_bits({7'd0, w, ^w}, 9);
`else
    shift_bits({8'd0, w}, 8);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; prog_en = 1'b0; ccff_head = 1'b0; li = 4'hF; ri = 4'hF;
    tick(); tick();
    checks++; if (ro !== 4'h0) begin errors++; $display("FAIL reset_right_out: got %h want 0", ro); end
    checks++; if (lo !== 4'h0) begin errors++; $display("FAIL reset_left_out: got %h want 0", lo); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_cfg_done: got %b want 0", cfg_done); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL reset_tail: got %b want 0", ccff_tail); end
    reset = 1'b0;
    tick();
    checks++; if (ro !== 4'h0) begin errors++; $display("FAIL unconfig_right_out: got %h want 0", ro); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL unconfig_cfg_done: got %b want 0", cfg_done); end
  endtask

  task automatic test_route(input logic [7:0] w, input int ncyc, input string tag);
    int            d[CW];
    logic [CW-1:0] hl[2];
    logic [CW-1:0] hr[2];
    load_cfg(w);
    li = 4'hF; ri = 4'hF;
    #1;
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL %s_exit_done: got %b want 0", tag, cfg_done); end
    checks++; if (ro !== 4'h0) begin errors++; $display("FAIL %s_exit_right_out: got %h want 0", tag, ro); end
    tick();
    for (int i = 0; i < CW; i++) begin
      d[i] = int'(w[2*i +: 2]);
      if (d[i] > PD) d[i] = PD;
    end
    hl[0] = '0; hl[1] = '0; hr[0] = '0; hr[1] = '0;
    for (int c = 0; c < ncyc; c++) begin
      logic [CW-1:0] nl, nr, er, el, gr, gl;
      nl = (c == 0) ? 4'hF : ((c < 4) ? 4'h0 : 4'($urandom));
      nr = 4'($urandom);
      for (int i = 0; i < CW; i++) begin
        case (d[i])
          0:       begin er[i] = nl[i];    el[i] = nr[i];    end
          1:       begin er[i] = hl[0][i]; el[i] = hr[0][i]; end
          default: begin er[i] = hl[1][i]; el[i] = hr[1][i]; end
        endcase
      end
      q_r.push_back(er);
      q_l.push_back(el);
      li = nl; ri = nr;
      #1;
      gr = q_r.pop_front();
      gl = q_l.pop_front();
      checks++; if (ro !== gr) begin errors++; $display("FAIL %s_right_out c%0d: got %h want %h", tag, c, ro, gr); end
      checks++; if (lo !== gl) begin errors++; $display("FAIL %s_left_out c%0d: got %h want %h", tag, c, lo, gl); end
      if (c == 0) begin
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", tag, cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL %s_err: got %b want 0", tag, cfg_err); end
      end
      hl[1] = hl[0]; hl[0] = nl;
      hr[1] = hr[0]; hr[0] = nr;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    li = 4'hF; ri = 4'hF;
    prog_en = 1'b1; ccff_head = 1'b1;
    #1;
    checks++; if (ro !== 4'h0) begin errors++; $display("FAIL b2b_right_out: got %h want 0", ro); end
    checks++; if (lo !== 4'h0) begin errors++; $display("FAIL b2b_left_out: got %h want 0", lo); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL b2b_done: got %b want 0", cfg_done); end
    tick();
    prog_en = 1'b0;
    tick();
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL b2b_short_err: got %b want 1", cfg_err); end
    test_route(8'h36, 10, "route_b");
  endtask

  task automatic test_bad_count(input int n, input string tag);
    shift_bits(16'hB6B6, n);
    li = 4'hF; ri = 4'hF;
    tick();
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL %s_err: got %b want 1", tag, cfg_err); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL %s_done: got %b want 0", tag, cfg_done); end
    checks++; if (ro !== 4'h0) begin errors++; $display("FAIL %s_right_out: got %h want 0", tag, ro); end
    checks++; if (lo !== 4'h0) begin errors++; $display("FAIL %s_left_out: got %h want 0", tag, lo); end
    tick();
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL %s_err_hold: got %b want 1", tag, cfg_err); end
    prog_en = 1'b1; ccff_head = 1'b0;
    #1;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL %s_err_clear: got %b want 0", tag, cfg_err); end
    tick();
    prog_en = 1'b0;
    tick();
  endtask

  task automatic test_tail();
    logic [7:0] pat;
    logic       b, e;
    pat = 8'b10110011;
    reset = 1'b1; prog_en = 1'b0;
    tick();
    reset = 1'b0;
    for (int n = 1; n <= CTOT + 8; n++) begin
      b = (n <= 8) ? pat[8-n] : 1'b0;
      prog_en = 1'b1; ccff_head = b;
      q_t.push_back(b);
      #1;
      if (n > CTOT) begin
        e = q_t.pop_front();
        checks++; if (ccff_tail !== e) begin errors++; $display("FAIL tail_bit n%0d: got %b want %b", n, ccff_tail, e); end
      end else begin
        checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL tail_early n%0d: got %b want 0", n, ccff_tail); end
      end
      tick();
    end
    prog_en = 1'b0; ccff_head = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    reset = 1'b1; prog_en = 1'b0;
    tick();
    reset = 1'b0;
    shift_bits(16'h000F, 4);
    reset = 1'b1; prog_en = 1'b1; ccff_head = 1'b1; li = 4'hF; ri = 4'hF;
    #1;
    checks++; if (ro !== 4'h0) begin errors++; $display("FAIL abort_rst_right_out: got %h want 0", ro); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL abort_rst_err: got %b want 0", cfg_err); end
    checks++; if (ccff_tail !== 1'b0) begin errors++; $display("FAIL abort_rst_tail: got %b want 0", ccff_tail); end
    tick();
    reset = 1'b0; prog_en = 1'b0; ccff_head = 1'b0;
    #1;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", cfg_err); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL abort_err_next: got %b want 0", cfg_err); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", cfg_done); end
    checks++; if (ro !== 4'h0) begin errors++; $display("FAIL abort_right_out: got %h want 0", ro); end
    test_route(8'h00, 6, "route_comb");
  endtask

`ifdef SB_PIPE_PARITY_EN
  task automatic test_parity();
    shift_bits({7'd0, 8'hE4, ~^8'hE4}, 9);
    tick();
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL parity_err: got %b want 1", cfg_err); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL parity_done: got %b want 0", cfg_done); end
    test_route(8'hE4, 6, "parity_ok");
  endtask
`endif

  initial begin
    reset = 1'b1; prog_en = 1'b0; ccff_head = 1'b0; li = '0; ri = '0;
    test_reset();
    test_route(8'hE4, 10, "route_a");
    test_back_to_back();
    test_bad_count(CTOT - 3, "short");
    test_bad_count(CTOT + 1, "long");
    test_tail();
    test_reset_abort();
`ifdef SB_PIPE_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
